// File: rtl/nano_dsi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nano_dsi_pkg
// Brief    : Shared FSM encoding, SoT byte and LP line levels for the DSI
//            data-lane transmitter.
// Revision : 1.0
// ============================================================================
package nano_dsi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LP01     = 4'd1,
        ST_LP00     = 4'd2,
        ST_HS_ZERO  = 4'd3,
        ST_HS_SYNC  = 4'd4,
        ST_HS_SOT   = 4'd5,
        ST_HS_DATA  = 4'd6,
        ST_HS_TRAIL = 4'd7,
        ST_HS_EXIT  = 4'd8
    } state_e;

    localparam logic [7:0] c_SOT_BYTE = 8'hB8;

    // LP levels packed as {lp_p, lp_n}
    localparam logic [1:0] c_LP_11 = 2'b11;
    localparam logic [1:0] c_LP_01 = 2'b01;
    localparam logic [1:0] c_LP_00 = 2'b00;

    function automatic logic [1:0] lp_level(input state_e s);
        case (s)
            ST_IDLE, ST_HS_EXIT: lp_level = c_LP_11;
            ST_LP01:             lp_level = c_LP_01;
            default:             lp_level = c_LP_00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/nano_dsi_timer.sv
`default_nettype none
// ============================================================================
// Module   : nano_dsi_timer
// Brief    : Loadable down-counter; expire_o is high while the count is zero.
// Revision : 1.0
// ============================================================================
module nano_dsi_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expire_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/nano_dsi_lane_tx.sv
`default_nettype none
// ============================================================================
// Module   : nano_dsi_lane_tx
// Brief    : MIPI DSI data-lane transmitter: LP-11 -> LP-01 -> LP-00 -> HS
//            burst (zero, SoT, payload, trail) -> LP-11, OUT_W bits per clk.
// Revision : 1.0
// ============================================================================
module nano_dsi_lane_tx
    import nano_dsi_pkg::*;
#(
    parameter int OUT_W = 1,
    parameter int TW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             lp_p,
    output logic             lp_n,
    output logic [OUT_W-1:0] hs_p,
    output logic [OUT_W-1:0] hs_n,
    input  logic             hs_start,
    input  logic [7:0]       hs_data,
    input  logic             hs_last,
    output logic             hs_ack,
    output logic             hs_rdy,
    input  logic             clk_sync,
    input  logic [TW-1:0]    cfg_lpx,
    input  logic [TW-1:0]    cfg_hs_prep,
    input  logic [TW-1:0]    cfg_hs_zero,
    input  logic [TW-1:0]    cfg_hs_trail,
    input  logic [TW-1:0]    cfg_hs_exit,
    input  logic             abort,
    output logic             busy
);

    localparam int         c_BEATS     = 8 / OUT_W;
    localparam logic [2:0] c_LAST_BEAT = 3'(c_BEATS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [2:0]       beat_q;
    logic [2:0]       beat_d;
    logic             last_q;
    logic             last_d;
    logic             bit7_q;
    logic             bit7_d;
    logic [1:0]       lp_q;
    logic [1:0]       lp_d;
    logic [OUT_W-1:0] hs_p_q;
    logic [OUT_W-1:0] hs_p_d;
    logic [OUT_W-1:0] hs_n_q;
    logic [OUT_W-1:0] hs_n_d;

    logic             w_expire;
    logic             w_beat_end;
    logic             w_ack;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;

    assign w_beat_end = (beat_q == c_LAST_BEAT);

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    nano_dsi_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .expire_o   (w_expire)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_ack   = 1'b0;
        case (state_q)
            ST_IDLE:     if (hs_start && !abort) state_d = ST_LP01;
            ST_LP01:     if (w_expire) state_d = ST_LP00;
            ST_LP00:     if (w_expire) state_d = ST_HS_ZERO;
            ST_HS_ZERO:  if (w_expire) state_d = ST_HS_SYNC;
            ST_HS_SYNC:  if (clk_sync) state_d = ST_HS_SOT;
            ST_HS_SOT: begin
                if (w_beat_end) begin
                    state_d = ST_HS_DATA;
                    w_ack   = 1'b1;
                end
            end
            ST_HS_DATA: begin
                if (w_beat_end) begin
                    if (last_q) begin
                        state_d = ST_HS_TRAIL;
                    end else begin
                        w_ack = 1'b1;
                    end
                end
            end
            ST_HS_TRAIL: if (w_expire) state_d = ST_HS_EXIT;
            ST_HS_EXIT:  if (w_expire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Abort wins over everything; inside HS_EXIT it simply restarts the exit timer.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_HS_EXIT;
            w_ack   = 1'b0;
        end
    end

    assign w_tmr_load = (state_d != state_q) || (abort && (state_q == ST_HS_EXIT));

    always_comb begin
        w_tmr_val = '0;
        case (state_d)
            ST_LP01:     w_tmr_val = cfg_lpx;
            ST_LP00:     w_tmr_val = cfg_hs_prep;
            ST_HS_ZERO:  w_tmr_val = cfg_hs_zero;
            ST_HS_TRAIL: w_tmr_val = cfg_hs_trail;
            ST_HS_EXIT:  w_tmr_val = cfg_hs_exit;
            default:     w_tmr_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        beat_d  = beat_q;
        last_d  = last_q;
        bit7_d  = bit7_q;
        if ((state_q == ST_HS_SYNC) && (state_d == ST_HS_SOT)) begin
            shift_d = c_SOT_BYTE;
            beat_d  = '0;
        end else if (w_ack) begin
            shift_d = hs_data;
            last_d  = hs_last;
            bit7_d  = hs_data[7];
            beat_d  = '0;
        end else if ((state_q == ST_HS_SOT) || (state_q == ST_HS_DATA)) begin
            shift_d = shift_q >> OUT_W;
            beat_d  = beat_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            bit7_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            bit7_q  <= bit7_d;
        end
    end

    // ------------------------------------------------------------------
    // Line drivers, registered from the current state (one-cycle lag)
    // ------------------------------------------------------------------
    always_comb begin
        lp_d   = lp_level(state_q);
        hs_p_d = '0;
        hs_n_d = '0;
        case (state_q)
            ST_HS_ZERO, ST_HS_SYNC: begin
                hs_n_d = '1;
            end
            ST_HS_SOT, ST_HS_DATA: begin
                hs_p_d = shift_q[OUT_W-1:0];
                hs_n_d = ~shift_q[OUT_W-1:0];
            end
            ST_HS_TRAIL: begin
                hs_p_d = {OUT_W{~bit7_q}};
                hs_n_d = {OUT_W{bit7_q}};
            end
            default: begin
                hs_p_d = '0;
                hs_n_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_q   <= c_LP_11;
            hs_p_q <= '0;
            hs_n_q <= '0;
        end else begin
            lp_q   <= lp_d;
            hs_p_q <= hs_p_d;
            hs_n_q <= hs_n_d;
        end
    end

    assign lp_p   = lp_q[1];
    assign lp_n   = lp_q[0];
    assign hs_p   = hs_p_q;
    assign hs_n   = hs_n_q;
    assign hs_ack = w_ack;
    assign hs_rdy = (state_q == ST_IDLE);
    assign busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nano_dsi_lane_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_nano_dsi_lane_tx
// Brief    : Scoreboard bench for nano_dsi_lane_tx at OUT_W = 1, 2 and 4.
// Revision : 1.0
// ============================================================================
module tb_nano_dsi_lane_tx;

    localparam int TW = 8;

    typedef struct {
        logic       start;
        logic       sync;
        logic       abort;
        logic       last;
        logic [7:0] data;
        logic       ack;
        logic       idle;
        logic [1:0] lp;
        logic [7:0] hp;
        logic [7:0] hn;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          hs_start;
    logic          clk_sync;
    logic          abort;
    logic          hs_last;
    logic [7:0]    hs_data;
    logic [TW-1:0] cfg_lpx, cfg_hs_prep, cfg_hs_zero, cfg_hs_trail, cfg_hs_exit;
    int            sel;
    logic [2:0]    start_v;

    logic       lp_p1, lp_n1, ack1, rdy1, busy1;
    logic [0:0] hs_p1, hs_n1;
    logic       lp_p2, lp_n2, ack2, rdy2, busy2;
    logic [1:0] hs_p2, hs_n2;
    logic       lp_p4, lp_n4, ack4, rdy4, busy4;
    logic [3:0] hs_p4, hs_n4;

    logic [1:0] m_lp;
    logic [7:0] m_hp, m_hn;
    logic       m_ack, m_rdy, m_busy;

    ent_t       sb_q[$];
    ent_t       prev;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] bytes_v [4];

    always #5 clk = ~clk;

    assign start_v[0] = hs_start && (sel == 0);
    assign start_v[1] = hs_start && (sel == 1);
    assign start_v[2] = hs_start && (sel == 2);

    nano_dsi_lane_tx #(.OUT_W(1), .TW(TW)) u_dut_w1 (
        .clk(clk), .rst(rst), .lp_p(lp_p1), .lp_n(lp_n1), .hs_p(hs_p1), .hs_n(hs_n1),
        .hs_start(start_v[0]), .hs_data(hs_data), .hs_last(hs_last), .hs_ack(ack1),
        .hs_rdy(rdy1), .clk_sync(clk_sync), .cfg_lpx(cfg_lpx), .cfg_hs_prep(cfg_hs_prep),
        .cfg_hs_zero(cfg_hs_zero), .cfg_hs_trail(cfg_hs_trail), .cfg_hs_exit(cfg_hs_exit),
        .abort(abort), .busy(busy1)
    );

    nano_dsi_lane_tx #(.OUT_W(2), .TW(TW)) u_dut_w2 (
        .clk(clk), .rst(rst), .lp_p(lp_p2), .lp_n(lp_n2), .hs_p(hs_p2), .hs_n(hs_n2),
        .hs_start(start_v[1]), .hs_data(hs_data), .hs_last(hs_last), .hs_ack(ack2),
        .hs_rdy(rdy2), .clk_sync(clk_sync), .cfg_lpx(cfg_lpx), .cfg_hs_prep(cfg_hs_prep),
        .cfg_hs_zero(cfg_hs_zero), .cfg_hs_trail(cfg_hs_trail), .cfg_hs_exit(cfg_hs_exit),
        .abort(abort), .busy(busy2)
    );

    nano_dsi_lane_tx #(.OUT_W(4), .TW(TW)) u_dut_w4 (
        .clk(clk), .rst(rst), .lp_p(lp_p4), .lp_n(lp_n4), .hs_p(hs_p4), .hs_n(hs_n4),
        .hs_start(start_v[2]), .hs_data(hs_data), .hs_last(hs_last), .hs_ack(ack4),
        .hs_rdy(rdy4), .clk_sync(clk_sync), .cfg_lpx(cfg_lpx), .cfg_hs_prep(cfg_hs_prep),
        .cfg_hs_zero(cfg_hs_zero), .cfg_hs_trail(cfg_hs_trail), .cfg_hs_exit(cfg_hs_exit),
        .abort(abort), .busy(busy4)
    );

    always_comb begin
        m_lp   = {lp_p1, lp_n1};
        m_hp   = {7'd0, hs_p1};
        m_hn   = {7'd0, hs_n1};
        m_ack  = ack1;
        m_rdy  = rdy1;
        m_busy = busy1;
        if (sel == 1) begin
            m_lp   = {lp_p2, lp_n2};
            m_hp   = {6'd0, hs_p2};
            m_hn   = {6'd0, hs_n2};
            m_ack  = ack2;
            m_rdy  = rdy2;
            m_busy = busy2;
        end else if (sel == 2) begin
            m_lp   = {lp_p4, lp_n4};
            m_hp   = {4'd0, hs_p4};
            m_hn   = {4'd0, hs_n4};
            m_ack  = ack4;
            m_rdy  = rdy4;
            m_busy = busy4;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Entry = one clock cycle: inputs to drive, ack/state flags for that cycle,
    // and the line levels the state of that cycle produces on the following cycle.
    function automatic ent_t mk(input logic [1:0] lp, input logic [7:0] hp,
                                input logic [7:0] hn, input logic idle);
        ent_t e;
        e.start = 1'b0;
        e.sync  = 1'b0;
        e.abort = 1'b0;
        e.last  = 1'($urandom);
        e.data  = 8'($urandom);
        e.ack   = 1'b0;
        e.idle  = idle;
        e.lp    = lp;
        e.hp    = hp;
        e.hn    = hn;
        return e;
    endfunction

    task automatic set_cfg(input int lpx, input int prep, input int zero, input int trail, input int ex);
        cfg_lpx      = TW'(lpx);
        cfg_hs_prep  = TW'(prep);
        cfg_hs_zero  = TW'(zero);
        cfg_hs_trail = TW'(trail);
        cfg_hs_exit  = TW'(ex);
    endtask

    task automatic build_burst(input int w, input logic [7:0] b [4], input int n,
                               input int sync_wait, input int abort_byte, input int abort_beat,
                               input bit noise, input bit exit_abort, input bit idle_abort);
        ent_t       e;
        int         beats;
        logic [7:0] mask;
        logic [7:0] cur;
        logic [7:0] hp;
        bit         aborted;
        beats   = 8 / w;
        mask    = 8'((1 << w) - 1);
        aborted = 1'b0;
        if (idle_abort) begin
            e = mk(2'b11, 8'h00, 8'h00, 1'b1);
            e.start = 1'b1;
            e.abort = 1'b1;
            sb_q.push_back(e);
        end
        e = mk(2'b11, 8'h00, 8'h00, 1'b1);
        e.start = 1'b1;
        sb_q.push_back(e);
        repeat (int'(cfg_lpx) + 1) begin
            e = mk(2'b01, 8'h00, 8'h00, 1'b0);
            e.sync = noise;
            sb_q.push_back(e);
        end
        repeat (int'(cfg_hs_prep) + 1) begin
            e = mk(2'b00, 8'h00, 8'h00, 1'b0);
            e.sync = noise;
            sb_q.push_back(e);
        end
        repeat (int'(cfg_hs_zero) + 1) begin
            e = mk(2'b00, 8'h00, mask, 1'b0);
            e.sync = noise;
            sb_q.push_back(e);
        end
        for (int i = 0; i <= sync_wait; i++) begin
            e = mk(2'b00, 8'h00, mask, 1'b0);
            e.sync = (i == sync_wait);
            sb_q.push_back(e);
        end
        for (int j = -1; (j < n) && !aborted; j++) begin
            cur = (j < 0) ? 8'hB8 : b[j];
            for (int k = 0; (k < beats) && !aborted; k++) begin
                hp = (cur >> (w * k)) & mask;
                e  = mk(2'b00, hp, ~hp & mask, 1'b0);
                if ((j == abort_byte) && (k == abort_beat)) begin
                    e.abort = 1'b1;
                    aborted = 1'b1;
                end else if ((k == beats - 1) && (j < n - 1)) begin
                    e.ack  = 1'b1;
                    e.data = b[j+1];
                    e.last = (j + 1 == n - 1);
                end
                sb_q.push_back(e);
            end
        end
        if (!aborted) begin
            hp = b[n-1][7] ? 8'h00 : mask;
            repeat (int'(cfg_hs_trail) + 1) sb_q.push_back(mk(2'b00, hp, ~hp & mask, 1'b0));
        end
        for (int i = 0; i < int'(cfg_hs_exit) + 1 + (exit_abort ? 1 : 0); i++) begin
            e = mk(2'b11, 8'h00, 8'h00, 1'b0);
            e.start = 1'b1;
            e.abort = exit_abort && (i == 0);
            sb_q.push_back(e);
        end
        repeat (3) sb_q.push_back(mk(2'b11, 8'h00, 8'h00, 1'b1));
    endtask

    task automatic drive(input ent_t e);
        hs_start = e.start;
        clk_sync = e.sync;
        abort    = e.abort;
        hs_data  = e.data;
        hs_last  = e.last;
    endtask

    task automatic run(input int max_cyc);
        ent_t e;
        int   n;
        n = 0;
        while ((sb_q.size() != 0) && (n < max_cyc)) begin
            e = sb_q.pop_front();
            @(negedge clk);
            drive(e);
            #1;
            check_eq("lp",   32'(m_lp),   32'(prev.lp));
            check_eq("hs_p", 32'(m_hp),   32'(prev.hp));
            check_eq("hs_n", 32'(m_hn),   32'(prev.hn));
            check_eq("ack",  32'(m_ack),  32'(e.ack));
            check_eq("busy", 32'(m_busy), 32'(!e.idle));
            check_eq("rdy",  32'(m_rdy),  32'(e.idle));
            prev = e;
            n++;
        end
    endtask

    // Called just after a negedge: pulses rst between edges with the first
    // (start) entry already driven, so the edge right after release honours it.
    task automatic reset_start();
        ent_t e;
        e = sb_q.pop_front();
        #1;
        rst = 1'b1;
        drive(e);
        #1;
        check_eq("rst_lp",   32'(m_lp),   32'h3);
        check_eq("rst_hs_p", 32'(m_hp),   32'h0);
        check_eq("rst_hs_n", 32'(m_hn),   32'h0);
        check_eq("rst_ack",  32'(m_ack),  32'h0);
        check_eq("rst_busy", 32'(m_busy), 32'h0);
        check_eq("rst_rdy",  32'(m_rdy),  32'h1);
        #1;
        rst  = 1'b0;
        prev = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        hs_start = 1'b0;
        clk_sync = 1'b0;
        abort    = 1'b0;
        hs_data  = 8'h00;
        hs_last  = 1'b0;
        sel      = 0;
        set_cfg(2, 2, 2, 2, 2);
        prev = mk(2'b11, 8'h00, 8'h00, 1'b1);

        // OUT_W=1, single byte 0x5A, all phases 3 cycles
        bytes_v = '{8'h5A, 8'h00, 8'h00, 8'h00};
        build_burst(1, bytes_v, 1, 0, -2, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset_start();
        run(1000);

        // OUT_W=4, three bytes, trail nibble 0; start+abort in IDLE ignored first
        sel = 2;
        set_cfg(1, 3, 0, 2, 1);
        bytes_v = '{8'h01, 8'h02, 8'h83, 8'h00};
        build_burst(4, bytes_v, 3, 2, -2, 0, 1'b0, 1'b0, 1'b1);
        run(1000);

        // OUT_W=2, long HS_SYNC wait, clk_sync toggling outside HS_SYNC
        sel = 1;
        set_cfg(2, 1, 3, 1, 2);
        bytes_v = '{8'hC3, 8'h3C, 8'h00, 8'h00};
        build_burst(2, bytes_v, 2, 10, -2, 0, 1'b1, 1'b0, 1'b0);
        run(1000);

        // OUT_W=2, abort inside byte 2 of 4, then abort again in HS_EXIT
        set_cfg(0, 1, 2, 1, 3);
        bytes_v = '{8'h96, 8'h69, 8'hF0, 8'h0F};
        build_burst(2, bytes_v, 4, 1, 1, 1, 1'b0, 1'b1, 1'b0);
        run(1000);

        // OUT_W=1, asynchronous reset in the middle of payload, then a clean burst
        sel = 0;
        set_cfg(2, 2, 2, 2, 2);
        bytes_v = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_burst(1, bytes_v, 4, 0, -2, 0, 1'b0, 1'b0, 1'b0);
        run(30);
        sb_q.delete();
        bytes_v = '{8'hA5, 8'h00, 8'h00, 8'h00};
        build_burst(1, bytes_v, 1, 1, -2, 0, 1'b0, 1'b0, 1'b0);
        reset_start();
        run(1000);

        // All timings zero: single-cycle phases; hs_start during HS_EXIT ignored
        set_cfg(0, 0, 0, 0, 0);
        bytes_v = '{8'hFF, 8'h80, 8'h00, 8'h00};
        build_burst(1, bytes_v, 2, 0, -2, 0, 1'b0, 1'b0, 1'b0);
        run(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
